ps2_key_event_decoder: RTL

- Consumes the per-byte output of the PS/2 receiver: one-cycle byte-strobe plus 8-bit scan-code byte and frame-error flag.
- Parses scan code set 2 multi-byte sequences (E0 extended, F0 break, E1 pause) into single key events.
- Tracks shift and caps-lock state and attaches an ASCII code to each event.
- Buffers events in a first-word-fall-through FIFO with a valid/ready handshake toward the consumer (CPU MMIO or LED logic).

---
 rtl/ps2_key_event_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Turns the per-byte stream of a PS/2 receiver into scan code set 2 key
//   events. The events carry ASCII and are buffered in a FWFT FIFO.
//
//   Parser: E0 marks an extended key, F0 marks a break (release), and E1
//   introduces the 8-byte pause sequence, which collapses into one event.
//   A prefix that is never completed is abandoned after TIMEOUT cycles.
//   Shift (left/right) and caps-lock state are tracked here, and ASCII is
//   derived from the state that held before the current event.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   BYTE_VALID          one-cycle strobe qualifying BYTE_DATA / BYTE_ERR
//   BYTE_DATA[7:0]      scan-code byte
//   BYTE_ERR            parity/framing error on this byte (byte discarded)
//   EVT_VALID           FIFO head holds an event
//   EVT_READY           consumer pops the head when EVT_VALID & EVT_READY
//   EVT_CODE[7:0]       final scan code (E1 for pause)
//   EVT_EXT, EVT_BREAK  E0-prefixed / key release
//   EVT_ASCII[7:0]      ASCII code or 00
//   SHIFT, CAPS         shift held / caps-lock toggle state
//   OVERFLOW            sticky: event dropped on full FIFO
//   FRAME_ERR           sticky: a byte arrived with BYTE_ERR
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BYTE_VALID,
    input  logic [7:0] BYTE_DATA,
    input  logic       BYTE_ERR,
    output logic       EVT_VALID,
    input  logic       EVT_READY,
    output logic [7:0] EVT_CODE,
    output logic       EVT_EXT,
    output logic       EVT_BREAK,
    output logic [7:0] EVT_ASCII,
    output logic       SHIFT,
    output logic       CAPS,
    output logic       OVERFLOW,
    output logic       FRAME_ERR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } evt_t;

    // Scan code set 2 to ASCII; letters are uppercased when upper is set.
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        case (code)
            8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
            8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
            8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
            8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
            8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
            8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
            8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
            8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
            8'h3E: c = 8'h38; 8'h46: c = 8'h39;
            8'h29: c = 8'h20; 8'h5A: c = 8'h0D; 8'h66: c = 8'h08; 8'h76: c = 8'h1B;
            default: c = 8'h00;
        endcase
        if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        return c;
    endfunction

    state_t             state;
    logic [2:0]         skip_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               shift_l, shift_r, caps_held;

    evt_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               emit, full, pop, push_ok;
    evt_t               evt_new, head;

    // Decode the incoming byte into the event (if any) it completes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        emit         = 1'b0;
        evt_new      = '0;
        evt_new.code = BYTE_DATA;
        if (BYTE_VALID && !BYTE_ERR) begin
            case (state)
                ST_IDLE:    emit = !(BYTE_DATA inside {8'hE0, 8'hF0, 8'hE1});
                ST_EXT: begin
                    emit        = !(BYTE_DATA inside {8'hE0, 8'hF0});
                    evt_new.ext = 1'b1;
                end
                ST_BRK: begin
                    emit        = 1'b1;
                    evt_new.brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    emit        = 1'b1;
                    evt_new.ext = 1'b1;
                    evt_new.brk = 1'b1;
                end
                ST_PAUSE: begin
                    emit         = (skip_cnt == 3'd6);
                    evt_new.code = 8'hE1;
                end
                default: emit = 1'b0;
            endcase
        end
        // Pre-update modifier state; E1 maps to 00 through the table.
        evt_new.ascii = evt_new.ext ? 8'h00
                                    : ascii_of(evt_new.code, (shift_l | shift_r) ^ CAPS);
    end

    assign EVT_VALID = (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = EVT_VALID && EVT_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = emit && (!full || pop);
    assign head      = mem[rd_ptr];

    // Head fields read as zero while empty so storage contents never leak out.
    always_comb begin
        EVT_CODE  = EVT_VALID ? head.code  : 8'h00;
        EVT_EXT   = EVT_VALID ? head.ext   : 1'b0;
        EVT_BREAK = EVT_VALID ? head.brk   : 1'b0;
        EVT_ASCII = EVT_VALID ? head.ascii : 8'h00;
    end

    assign SHIFT = shift_l | shift_r;

    // NOTE: event storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= evt_new;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            tmo_cnt   <= '0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_held <= 1'b0;
            CAPS      <= 1'b0;
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            // FIFO bookkeeping.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (emit && full && !pop) OVERFLOW <= 1'b1;

            // Parser and prefix timeout; an arriving byte overrides the timeout.
            if (BYTE_VALID) begin
                tmo_cnt <= '0;
                if (BYTE_ERR) begin
                    FRAME_ERR <= 1'b1;
                    state     <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (BYTE_DATA == 8'hE0)      state <= ST_EXT;
                            else if (BYTE_DATA == 8'hF0) state <= ST_BRK;
                            else if (BYTE_DATA == 8'hE1) begin
                                state    <= ST_PAUSE;
                                skip_cnt <= '0;
                            end
                        end
                        ST_EXT: begin
                            if (BYTE_DATA == 8'hF0)      state <= ST_EXT_BRK;
                            else if (BYTE_DATA != 8'hE0) state <= ST_IDLE;
                        end
                        ST_PAUSE: begin
                            if (skip_cnt == 3'd6) state <= ST_IDLE;
                            else                  skip_cnt <= skip_cnt + 3'd1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end

            // Modifier tracking for non-extended events.
            if (emit && !evt_new.ext) begin
                case (evt_new.code)
                    8'h12: shift_l <= !evt_new.brk;
                    8'h59: shift_r <= !evt_new.brk;
                    8'h58: begin
                        if (evt_new.brk) begin
                            caps_held <= 1'b0;
                        end else begin
                            // Typematic repeats arrive while held and must not toggle.
                            if (!caps_held) CAPS <= !CAPS;
                            caps_held <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
